// File: rtl/zombie_pkg.sv
// Shared constants for the punch-zombie game sequencer: monster types,
// FSM state encoding and the default number of on-screen slots.
package zombie_pkg;

    // Number of on-screen monster positions (queue depth).
    localparam int DEFAULT_SLOTS = 6;

    // Monster types; EMPTY marks a blank slot and is never a valid random value.
    localparam logic [1:0] EMPTY    = 2'd0;
    localparam logic [1:0] ZOMBIE_A = 2'd1;
    localparam logic [1:0] ZOMBIE_B = 2'd2;
    localparam logic [1:0] ZOMBIE_C = 2'd3;

    // FSM state encoding, also exported on the debug state port.
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FILL   = 3'd1;
    localparam logic [2:0] S_PLAY   = 3'd2;
    localparam logic [2:0] S_REFILL = 3'd3;
    localparam logic [2:0] S_OVER   = 3'd4;

endpackage

// File: rtl/zombie_game_ctrl_type_queue.sv
// Monster-type shadow queue. It mirrors the picture shift registers of the
// matrix generator: a push drops slot 0, shifts everything one position
// toward the front and loads the new type at the tail.
module type_queue
    import zombie_pkg::*;
#(
    parameter int SLOTS = DEFAULT_SLOTS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       clear,
    input  logic [1:0] push_type,
    output logic [1:0] front
);

    logic [SLOTS-1:0][1:0] slots;

    // Shift toward slot 0 on push; clear blanks every slot at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots <= '0;
        end else if (clear) begin
            slots <= '0;
        end else if (push) begin
            for (int i = 0; i < SLOTS - 1; i++) begin
                slots[i] <= slots[i+1];
            end
            slots[SLOTS-1] <= push_type;
        end
    end

    assign front = slots[0];

endmodule

// File: rtl/zombie_game_ctrl.sv
// Game sequencer for the punch-zombie LED-matrix game. Fills the monster
// queue from the random source, judges punches against the front monster,
// issues advance/clear commands to the picture datapath and keeps score,
// lives and the game timer.
module zombie_game_ctrl
    import zombie_pkg::*;
#(
    parameter int SLOTS      = DEFAULT_SLOTS,
    parameter int LIVES      = 3,
    parameter int TIME_LIMIT = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] btn,
    input  logic       tick,
    input  logic       rnd_valid,
    input  logic [1:0] rnd_data,
    output logic       rnd_req,
    output logic       advance,
    output logic [1:0] new_type,
    output logic       clear,
    output logic [1:0] front_type,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic [7:0] time_left,
    output logic       gameover,
    output logic [2:0] state
);

    localparam int CW = $clog2(SLOTS + 1);

    logic [2:0]    btn_s;
    logic [2:0]    btn_d;
    logic [2:0]    edges;
    logic [2:0]    target;
    logic [CW-1:0] fill_cnt;
    logic [2:0]    next_state;
    logic          in_game;
    logic          expiring;
    logic          expired;
    logic          stop;
    logic          hit;
    logic          miss;
    logic          accept;
    logic          fill_done;
    logic          start_game;
    logic          enter_over;

    // Judge logic: button edges, time-out, random acceptance. A tick that
    // takes the timer to zero freezes judging so a coincident hit is lost.
    always_comb begin
        edges      = btn_s & ~btn_d;
        in_game    = (state == S_PLAY) || (state == S_REFILL);
        expiring   = in_game && tick && (time_left == 8'd1);
        expired    = in_game && (time_left == 8'd0);
        stop       = expiring || expired;
        case (front_type)
            ZOMBIE_A: target = 3'b001;
            ZOMBIE_B: target = 3'b010;
            ZOMBIE_C: target = 3'b100;
            default:  target = 3'b000;
        endcase
        hit        = (state == S_PLAY) && !stop && (edges != 3'b000) && (edges == target);
        miss       = (state == S_PLAY) && !stop && (edges != 3'b000) && !hit;
        accept     = ((state == S_FILL) || ((state == S_REFILL) && !stop))
                     && rnd_valid && (rnd_data != EMPTY);
        fill_done  = (state == S_FILL) && accept && (fill_cnt == CW'(SLOTS - 1));
        start_game = start && ((state == S_IDLE) || (state == S_OVER));
    end

    // Next-state selection; time-out outranks hit/miss.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start_game) next_state = S_FILL;
            S_FILL:   if (fill_done) next_state = S_PLAY;
            S_PLAY: begin
                if (expired)                        next_state = S_OVER;
                else if (hit)                       next_state = S_REFILL;
                else if (miss && lives == 2'd1)     next_state = S_OVER;
            end
            S_REFILL: begin
                if (expired)     next_state = S_OVER;
                else if (accept) next_state = S_PLAY;
            end
            S_OVER:   if (start_game) next_state = S_FILL;
            default:  next_state = S_IDLE;
        endcase
        enter_over = (next_state == S_OVER) && (state != S_OVER);
    end

    // State register and the two-stage button history used for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            btn_s <= 3'b000;
            btn_d <= 3'b000;
        end else begin
            state <= next_state;
            btn_s <= btn;
            btn_d <= btn_s;
        end
    end

    // Score, lives, timer and fill counter; all re-initialised on start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            score     <= 8'd0;
            lives     <= 2'(LIVES);
            time_left <= 8'(TIME_LIMIT);
            fill_cnt  <= '0;
        end else if (start_game) begin
            score     <= 8'd0;
            lives     <= 2'(LIVES);
            time_left <= 8'(TIME_LIMIT);
            fill_cnt  <= '0;
        end else begin
            if (in_game && tick && (time_left != 8'd0)) time_left <= time_left - 8'd1;
            if (hit && (score != 8'd255))              score     <= score + 8'd1;
            if (miss && (lives != 2'd0))               lives     <= lives - 2'd1;
            if ((state == S_FILL) && accept)           fill_cnt  <= fill_cnt + CW'(1);
        end
    end

    // Registered datapath commands and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_req  <= 1'b0;
            advance  <= 1'b0;
            new_type <= EMPTY;
            clear    <= 1'b0;
            gameover <= 1'b0;
        end else begin
            rnd_req  <= ((next_state == S_FILL) || (next_state == S_REFILL)) && !expiring;
            advance  <= accept;
            new_type <= accept ? rnd_data : EMPTY;
            clear    <= enter_over;
            gameover <= (next_state == S_OVER);
        end
    end

    type_queue #(
        .SLOTS(SLOTS)
    ) u_queue (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .clear    (enter_over),
        .push_type(rnd_data),
        .front    (front_type)
    );

endmodule

// File: tb/tb_zombie_game_ctrl.sv
// Self-checking bench for zombie_game_ctrl. Expected advance types go into a
// scoreboard queue when random values are driven and are popped when the DUT
// pulses advance; a small slot model predicts front_type.
module tb_zombie_game_ctrl;
    import zombie_pkg::*;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] btn;
    logic       tick;
    logic       rnd_valid;
    logic [1:0] rnd_data;
    logic       rnd_req;
    logic       advance;
    logic [1:0] new_type;
    logic       clear;
    logic [1:0] front_type;
    logic [7:0] score;
    logic [1:0] lives;
    logic [7:0] time_left;
    logic       gameover;
    logic [2:0] state;

    int tests_run    = 0;
    int tests_failed = 0;
    int adv_count    = 0;
    int adv_base     = 0;
    int pushed_total = 0;
    int exp_lives    = 3;

    logic [1:0] exp_q [$];
    logic [1:0] model [6];
    logic [1:0] popped;
    logic [1:0] seq_a [7] = '{2'd1, 2'd0, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    logic [1:0] seq_b [6] = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd3};
    logic [1:0] seq_c [6] = '{2'd3, 2'd3, 2'd2, 2'd1, 2'd1, 2'd2};

    zombie_game_ctrl #(
        .SLOTS     (6),
        .LIVES     (3),
        .TIME_LIMIT(3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .btn       (btn),
        .tick      (tick),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .rnd_req   (rnd_req),
        .advance   (advance),
        .new_type  (new_type),
        .clear     (clear),
        .front_type(front_type),
        .score     (score),
        .lives     (lives),
        .time_left (time_left),
        .gameover  (gameover),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the bench's expectation.
    task automatic check_output(input string tag, input int actual, input int expected);
        tests_run++;
        if (actual != expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 6; i++) model[i] = EMPTY;
    endtask

    task automatic model_push(input logic [1:0] t);
        for (int i = 0; i < 5; i++) model[i] = model[i+1];
        model[5] = t;
    endtask

    // Drive one random value for one cycle; nonzero values are expected to be taken.
    task automatic apply_stimulus(input logic [1:0] t);
        rnd_valid = 1'b1;
        rnd_data  = t;
        if (t != EMPTY) begin
            exp_q.push_back(t);
            model_push(t);
            pushed_total++;
        end
        step();
    endtask

    task automatic rnd_idle();
        rnd_valid = 1'b0;
        rnd_data  = 2'd0;
    endtask

    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
        exp_lives = 3;
        check_output("start_state", state, S_FILL);
        check_output("start_req", rnd_req, 1);
        check_output("start_score", score, 0);
        check_output("start_lives", lives, 3);
        check_output("start_time", time_left, 3);
    endtask

    task automatic apply_press(input logic [2:0] b);
        btn = b;
        step();
        btn = 3'b000;
        step();
    endtask

    // Scoreboard side: every advance pulse must match the oldest pending type.
    always @(negedge clk) begin
        if (!rst && advance) begin
            adv_count++;
            check_output("adv_pending", (exp_q.size() != 0) ? 1 : 0, 1);
            if (exp_q.size() != 0) begin
                popped = exp_q.pop_front();
                check_output("adv_type", new_type, popped);
            end
        end
    end

    // Hard bound on simulation length.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; start = 1'b0; btn = 3'b000; tick = 1'b0;
        rnd_valid = 1'b0; rnd_data = 2'd0;
        model_clear();
        step();
        step();
        check_output("rst_state", state, S_IDLE);
        check_output("rst_front", front_type, 0);
        check_output("rst_score", score, 0);
        check_output("rst_lives", lives, 3);
        check_output("rst_time", time_left, 3);
        check_output("rst_req", rnd_req, 0);
        check_output("rst_adv", advance, 0);
        check_output("rst_clear", clear, 0);
        check_output("rst_over", gameover, 0);
        check_output("rst_newtype", new_type, 0);
        rst = 1'b0;
        step();

        // Fill with a rejected zero in the middle, back-to-back values.
        start_game();
        adv_base = adv_count;
        for (int i = 0; i < 7; i++) begin
            apply_stimulus(seq_a[i]);
            check_output("fill_req", rnd_req, (i < 6) ? 1 : 0);
        end
        rnd_idle();
        step();
        check_output("fill_adv_count", adv_count - adv_base, 6);
        check_output("fill_front", front_type, model[0]);
        check_output("fill_state", state, S_PLAY);

        // Hit on front=1, then refill with 3.
        apply_press(3'b001);
        check_output("hit_score", score, 1);
        check_output("hit_req", rnd_req, 1);
        check_output("hit_state", state, S_REFILL);
        adv_base = adv_count;
        apply_stimulus(2'd3);
        rnd_idle();
        check_output("refill_state", state, S_PLAY);
        check_output("refill_req", rnd_req, 0);
        check_output("refill_front", front_type, model[0]);
        step();
        check_output("refill_adv_count", adv_count - adv_base, 1);

        // Three misses: wrong button, two buttons, wrong button.
        apply_press(3'b001);
        exp_lives--;
        check_output("miss1_lives", lives, exp_lives);
        apply_press(3'b101);
        exp_lives--;
        check_output("miss2_lives", lives, exp_lives);
        apply_press(3'b100);
        exp_lives--;
        model_clear();
        check_output("miss3_lives", lives, exp_lives);
        check_output("over_state", state, S_OVER);
        check_output("over_clear", clear, 1);
        check_output("over_flag", gameover, 1);
        step();
        check_output("over_clear_once", clear, 0);
        check_output("over_flag_held", gameover, 1);
        check_output("over_score", score, 1);
        check_output("over_front", front_type, model[0]);

        // Held button counts once.
        start_game();
        check_output("restart_over", gameover, 0);
        for (int i = 0; i < 6; i++) apply_stimulus(seq_b[i]);
        rnd_idle();
        check_output("hold_front", front_type, model[0]);
        btn = 3'b001;
        for (int i = 0; i < 10; i++) step();
        btn = 3'b000;
        check_output("hold_score", score, 1);
        check_output("hold_state", state, S_REFILL);
        check_output("hold_lives", lives, 3);
        apply_stimulus(2'd2);
        rnd_idle();
        check_output("hold_front2", front_type, model[0]);

        // Hit on front=2, then reset while the refill request is pending.
        apply_press(3'b010);
        check_output("pre_rst_req", rnd_req, 1);
        rst = 1'b1;
        #1;
        check_output("async_rst_state", state, S_IDLE);
        check_output("async_rst_req", rnd_req, 0);
        model_clear();
        step();
        rst = 1'b0;
        step();
        start_game();
        adv_base = adv_count;
        for (int i = 0; i < 6; i++) apply_stimulus(seq_c[i]);
        rnd_idle();
        check_output("post_rst_state", state, S_PLAY);
        check_output("post_rst_front", front_type, model[0]);
        step();
        check_output("post_rst_adv_count", adv_count - adv_base, 6);

        // Time-out: third tick coincides with a hit edge; the hit is lost.
        tick = 1'b1; step(); tick = 1'b0;
        check_output("tick1_time", time_left, 2);
        tick = 1'b1; step(); tick = 1'b0;
        check_output("tick2_time", time_left, 1);
        btn = 3'b100;
        step();
        tick = 1'b1;
        btn = 3'b000;
        step();
        tick = 1'b0;
        check_output("tick3_time", time_left, 0);
        check_output("tick3_score", score, 0);
        check_output("tick3_not_over_yet", gameover, 0);
        step();
        check_output("timeout_state", state, S_OVER);
        check_output("timeout_flag", gameover, 1);
        check_output("timeout_clear", clear, 1);
        step();
        check_output("timeout_clear_once", clear, 0);
        check_output("timeout_score", score, 0);

        step();
        check_output("sb_empty", exp_q.size(), 0);
        check_output("adv_total", adv_count, pushed_total);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/zombie_game_ctrl.md
# zombie_game_ctrl

Game sequencer for the punch-zombie LED-matrix game. It owns the monster-type queue, which shadows the picture shift registers in the matrix generator. It fills the queue at game start from the random source, judges button punches against the front monster, and drives one-cycle `advance`/`clear` commands to the picture datapath. It also keeps score, lives and the game timer and raises `gameover`.

## Interface
Parameters:
- `SLOTS`, 6: queue depth, equal to the number of on-screen monster positions.
- `LIVES`, 3: misses allowed before game over, range 1..3.
- `TIME_LIMIT`, 60: game length in `tick` pulses, range 1..255.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse; begins a game from IDLE or OVER.
- `btn`, in, 3: punch buttons, already synchronized and debounced. `btn[k]` kills monster type k+1.
- `tick`, in, 1: one-cycle game-time pulse, nominally 1 Hz.
- `rnd_valid`, in, 1: random value valid this cycle.
- `rnd_data`, in, 2: random monster type.
- `rnd_req`, out, 1: controller is waiting for a random value.
- `advance`, out, 1: one-cycle pulse. The datapath drops the front slot, shifts, and loads `new_type` at the tail.
- `new_type`, out, 2: type loaded at the tail. Valid only while `advance`=1.
- `clear`, out, 1: one-cycle pulse; the datapath blanks all slots.
- `front_type`, out, 2: type in slot 0, which is the punch target.
- `score`, out, 8: hits this game, saturating at 255.
- `lives`, out, 2: remaining lives.
- `time_left`, out, 8: remaining ticks.
- `gameover`, out, 1: high in OVER.
- `state`, out, 3: current FSM state, for debug.

## Operation
- Monster types: 0 = EMPTY; 1, 2, 3 = zombie types. A `rnd_data` of 0 is rejected: it is ignored and `rnd_req` stays high.
- FSM states: IDLE, FILL, PLAY, REFILL, OVER.
- IDLE
  - `start` → FILL.
  - On entry to FILL: score=0, lives=LIVES, time_left=TIME_LIMIT, fill counter=0.
- FILL
  - `rnd_req`=1.
  - Each accepted `rnd_valid` produces an `advance` pulse with `new_type`=`rnd_data`, and the fill counter increments.
  - After the SLOTS-th advance → PLAY.
  - `tick` is ignored.
- PLAY
  - Button rising edges are computed internally from a one-cycle-delayed copy of `btn` (reset value 0).
  - Exactly one rising edge on bit k with k+1 == `front_type` is a hit: score +1 (saturating), → REFILL.
  - Any other nonzero edge set is a miss: exactly one wrong button, or two or more edges in the same cycle. A miss costs lives −1; if lives reaches 0 → OVER.
  - `tick`: time_left −1; reaching 0 → OVER.
- REFILL
  - `rnd_req`=1.
  - An accepted random value produces an `advance` pulse with that type, → PLAY.
  - Button edges are ignored; `tick` still counts down.
- OVER
  - `clear` pulses for one cycle on entry.
  - `gameover`=1; score is held.
  - `start` → FILL, with the same re-initialisation as from IDLE.
- Priority within a cycle: time-out > hit/miss. On a tick that reaches 0 in the same cycle as a hit, the hit is not scored and the controller goes to OVER.
- In REFILL, time-out abandons the pending request: `rnd_req` drops and no `advance` is issued.
- `start` is ignored in FILL, PLAY and REFILL.

## Timing
- Reset values:
  - state=IDLE, queue all EMPTY, `front_type`=0.
  - score=0, lives=LIVES, time_left=TIME_LIMIT.
  - `rnd_req`, `advance`, `clear`, `gameover` all 0; `new_type`=0.
- All outputs are registered.
- Button edge latency:
  - Edge present at `btn` in cycle N → judged in cycle N+1.
  - score/lives updated at N+2.
  - `rnd_req` high from N+2 after a hit.
- Random acceptance: `rnd_valid`=1 with nonzero data in cycle M → `advance`, `new_type` and the queue update all at M+1. `rnd_req` is 0 at M+1 unless more values are still needed (FILL).
- Back-to-back `rnd_valid` in FILL is accepted every cycle.
- `tick` in cycle T → `time_left` updated at T+1; `gameover` high at T+2 when the count reaches 0.
- `clear` is high for exactly the first cycle of OVER.
- Reset asserted mid-game returns to IDLE immediately and drops any pending request.

## Structure
- Package `zombie_pkg` holds:
  - the FSM state enum;
  - the monster-type constants EMPTY, ZOMBIE_A, ZOMBIE_B, ZOMBIE_C;
  - the default SLOTS.
- Sub-module `type_queue`: SLOTS×2-bit shift register with `push`/`clear` inputs and a `front` output. It mirrors the picture registers exactly.
- The FSM, edge detector, and score/lives/timer counters live in the top module.

## Test plan
- Reset, `start`, then `rnd_data` sequence 1, 0, 2, 3, 1, 2, 3:
  - exactly 6 `advance` pulses; the 0 is rejected;
  - `front_type`=1; state=PLAY.
- PLAY with front=1, pulse `btn[0]`:
  - score=1 two cycles later;
  - `rnd_req` high; after `rnd_data`=3, one `advance`; new front=2.
- Front=2, press `btn[0]`, then `btn[0]`+`btn[2]` together, then `btn[2]` with LIVES=3:
  - lives 2, 1, then 0;
  - OVER with `clear` high for one cycle; score unchanged.
- TIME_LIMIT=3: three `tick` pulses → OVER. A hit edge coincident with the third tick is not scored.
- Hold `btn[0]` high for 10 cycles with front=1: only one hit is counted.
- Assert `rst` during REFILL:
  - state=IDLE and `rnd_req`=0 immediately;
  - a subsequent `start` performs a full FILL.
